msdf_otf_converter: RTL and testbench

MSDF_OTF_CONVERTER -- requirements
Module: msdf_otf_converter

---
 rtl/msdf_otf_converter.sv | 107 ++++++++++
 tb/tb_msdf_otf_converter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/msdf_otf_converter.sv
// Converts an MSD-first radix-2 signed-digit stream into a two's-complement
// frame value using on-the-fly conversion (Q / QM register pair, no CPA).
module msdf_otf_converter #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   in_digit,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N:0]   result,
  output logic         result_valid,
  input  logic         result_ready,
  output logic         digit_err
);

  localparam int unsigned CW = $clog2(N + 1);

  // Digit codes shared with the MSDF adder.
  localparam logic [1:0] R2_ZERO    = 2'b00;
  localparam logic [1:0] R2_POS_ONE = 2'b01;
  localparam logic [1:0] R2_NEG_ONE = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_t;

  state_t        state, state_next;
  logic [N:0]    q, qm, q_next, qm_next;
  logic [CW-1:0] cnt;
  logic          accept, last, illegal;

  // Handshake decode; ready depends only on state to avoid a comb loop.
  always_comb begin
    accept = in_valid && (state != DONE);
    last   = (cnt == CW'(N - 1));
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next   = state;
    in_ready     = 1'b1;
    result_valid = 1'b0;
    case (state)
      IDLE: if (accept) state_next = last ? DONE : ACC;
      ACC:  if (accept && last) state_next = DONE;
      DONE: begin
        in_ready     = 1'b0;
        result_valid = 1'b1;
        if (result_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // On-the-fly append: each update is a shift plus a constant LSB.
  always_comb begin
    illegal = 1'b0;
    q_next  = {q[N-1:0], 1'b0};
    qm_next = {qm[N-1:0], 1'b1};
    case (in_digit)
      R2_POS_ONE: begin
        q_next  = {q[N-1:0], 1'b1};
        qm_next = {q[N-1:0], 1'b0};
      end
      R2_NEG_ONE: begin
        q_next  = {qm[N-1:0], 1'b1};
        qm_next = {qm[N-1:0], 1'b0};
      end
      R2_ZERO: begin
        q_next  = {q[N-1:0], 1'b0};
        qm_next = {qm[N-1:0], 1'b1};
      end
      default: illegal = 1'b1;
    endcase
  end

  // State, conversion registers, digit counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      q         <= '0;
      qm        <= '1;
      cnt       <= '0;
      digit_err <= 1'b0;
    end else begin
      state <= state_next;
      if (state == DONE) begin
        if (result_ready) begin
          q   <= '0;
          qm  <= '1;
          cnt <= '0;
        end
      end else if (accept) begin
        q         <= q_next;
        qm        <= qm_next;
        cnt       <= cnt + CW'(1);
        digit_err <= (state == IDLE) ? illegal : (digit_err | illegal);
      end
    end
  end

  always_comb result = q;

endmodule

// File: tb/tb_msdf_otf_converter.sv
// Self-checking bench: integer-sum reference model plus directed frames
// with hand-computed values, followed by randomized traffic.
module tb_msdf_otf_converter;

  localparam int unsigned N = 8;
  localparam logic [1:0] DZ = 2'b00;
  localparam logic [1:0] DP = 2'b01;
  localparam logic [1:0] DN = 2'b11;
  localparam logic [1:0] DX = 2'b10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] in_digit = DZ;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [N:0] result;
  logic       result_valid;
  logic       result_ready = 1'b1;
  logic       digit_err;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  msdf_otf_converter #(.N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_digit     (in_digit),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .digit_err    (digit_err)
  );

  always #5 clk = ~clk;

  // Reference model: frame value as a plain signed integer sum.
  bit m_done = 1'b0;
  int m_cnt  = 0;
  int m_sum  = 0;
  bit m_err  = 1'b0;

  function automatic int dval(input logic [1:0] d);
    if (d == DP) return 1;
    if (d == DN) return -1;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_done = 1'b0; m_cnt = 0; m_sum = 0; m_err = 1'b0;
    end else if (m_done) begin
      if (result_ready) begin
        m_done = 1'b0; m_cnt = 0; m_sum = 0;
      end
    end else if (in_valid) begin
      if (m_cnt == 0) begin
        m_err = 1'b0; m_sum = 0;
      end
      if (in_digit == DX) m_err = 1'b1;
      m_sum = m_sum + dval(in_digit) * (1 << (N - 1 - m_cnt));
      m_cnt = m_cnt + 1;
      if (m_cnt == N) m_done = 1'b1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      logic [N:0] exp_res;
      exp_res = m_sum[N:0];
      chk("in_ready", int'(in_ready), int'(!m_done));
      chk("result_valid", int'(result_valid), int'(m_done));
      chk("digit_err", int'(digit_err), int'(m_err));
      if (m_done)
        chk("result_done", int'(result), int'(exp_res));
      else if (m_cnt == 0)
        chk("result_idle", int'(result), 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one digit and hold it until accepted (bounded wait).
  task automatic send(input logic [1:0] d);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_digit = d;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) chk("send_timeout", 1, 0);
    tick();
    in_valid = 1'b0;
  endtask

  // Digit k sits at frame[2N-1-2k -: 2]; optional idle gap after two digits.
  task automatic run_frame(input logic [2*N-1:0] frame, input int ga, input int gb,
                           input int glen);
    for (int k = 0; k < N; k++) begin
      send(frame[2*N-1-2*k -: 2]);
      if (k == ga || k == gb)
        for (int g = 0; g < glen; g++) tick();
    end
  endtask

  localparam logic [15:0] F59  = {DZ, DP, DZ, DN, DP, DP, DZ, DN};
  localparam logic [15:0] F98  = {DP, DZ, DN, DZ, DP, DN, DN, DZ};
  localparam logic [15:0] FNEG = {8{DN}};
  localparam logic [15:0] FPOS = {8{DP}};
  localparam logic [15:0] FZER = {8{DZ}};
  localparam logic [15:0] FERR = {DP, DP, DP, DX, DP, DP, DP, DP};

  initial begin
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    cmp_en = 1'b1;
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_result_valid", int'(result_valid), 0);
    chk("reset_result", int'(result), 0);
    chk("reset_digit_err", int'(digit_err), 0);

    // +59 frame: valid exactly one cycle, one cycle after the 8th digit.
    run_frame(F59, -1, -1, 0);
    chk("f59_valid", int'(result_valid), 1);
    chk("f59_result", int'(result), 'h03B);
    chk("model_f59", m_sum, 59);
    tick();
    chk("f59_pulse_len", int'(result_valid), 0);

    run_frame(F98, -1, -1, 0);
    chk("f98_result", int'(result), 'h062);
    chk("model_f98", m_sum, 98);
    tick();
    run_frame(FNEG, -1, -1, 0);
    chk("fneg_result", int'(result), 'h101);
    chk("model_fneg", m_sum, -255);
    tick();
    run_frame(FPOS, -1, -1, 0);
    chk("fpos_result", int'(result), 'h0FF);
    tick();
    run_frame(FZER, -1, -1, 0);
    chk("fzero_result", int'(result), 'h000);
    tick();

    // Stalls after digits 2 and 5 (1-based) are transparent.
    run_frame(F59, 1, 4, 3);
    chk("gap_result", int'(result), 'h03B);
    tick();

    // Back-pressure in DONE with a digit waiting.
    result_ready = 1'b0;
    run_frame(F59, -1, -1, 0);
    in_valid = 1'b1;
    in_digit = DP;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_in_ready", int'(in_ready), 0);
      chk("hold_result", int'(result), 'h03B);
    end
    result_ready = 1'b1;
    tick();
    chk("after_hs_in_ready", int'(in_ready), 1);
    chk("after_hs_valid", int'(result_valid), 0);
    chk("hold_not_accepted", m_cnt, 0);
    in_valid = 1'b0;
    tick();

    // Reset mid-frame discards the partial result.
    for (int k = 0; k < 4; k++) send(F98[15-2*k -: 2]);
    chk("pre_rst_valid", int'(result_valid), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("post_rst_valid", int'(result_valid), 0);
    chk("post_rst_result", int'(result), 0);
    run_frame(F98, -1, -1, 0);
    chk("rst_f98_result", int'(result), 'h062);
    tick();

    // Illegal code at digit index 3 behaves as zero and flags the frame.
    run_frame(FERR, -1, -1, 0);
    chk("err_result", int'(result), 'h0EF);
    chk("err_flag", int'(digit_err), 1);
    chk("model_err", m_sum, 239);
    tick();
    chk("err_sticky_idle", int'(digit_err), 1);
    send(DZ);
    chk("err_cleared", int'(digit_err), 0);
    for (int k = 1; k < N; k++) send(DZ);
    tick();

    // Randomized traffic including illegal codes, stalls and resets.
    for (int i = 0; i < 3000; i++) begin
      in_valid     = ($urandom_range(0, 3) != 0);
      in_digit     = 2'($urandom_range(0, 3));
      result_ready = ($urandom_range(0, 2) != 0);
      rst          = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    result_ready = 1'b1;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
